// File: rtl/memb_streamer.sv
// rtl/memb_streamer.sv - B-matrix store that streams rows, then zero flush, into memB (optional: MEMB_STREAMER_TRANSPOSE_EN)
module memb_streamer #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(DIM)-1:0]    wr_row,
  input  logic signed [BITS_AB-1:0] wr_data [DIM-1:0],
  input  logic                      start,
`ifdef MEMB_STREAMER_TRANSPOSE_EN
  input  logic                      transpose,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      en_out,
  output logic signed [BITS_AB-1:0] Bout [DIM-1:0]
);

  localparam int RW = $clog2(DIM);
  localparam int FW = $clog2(2 * DIM);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;
  logic [FW-1:0]     flush_cnt_q, flush_cnt_d;
  logic signed [BITS_AB-1:0] mem_q [DIM][DIM];

`ifdef MEMB_STREAMER_TRANSPOSE_EN
  logic transpose_q, transpose_d;
`endif

  // Matrix storage: row writes accepted only while idle and in range
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++)
          mem_q[i][j] <= '0;
    end else if (state_q == S_IDLE && wr_en && (32'(wr_row) < DIM)) begin
      for (int j = 0; j < DIM; j++)
        mem_q[wr_row][j] <= wr_data[j];
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      flush_cnt_q <= '0;
`ifdef MEMB_STREAMER_TRANSPOSE_EN
      transpose_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      flush_cnt_q <= flush_cnt_d;
`ifdef MEMB_STREAMER_TRANSPOSE_EN
      transpose_q <= transpose_d;
`endif
    end
  end

  // Next-state: DIM stream cycles, then 2*DIM-1 flush cycles, then one done cycle
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    flush_cnt_d = flush_cnt_q;
`ifdef MEMB_STREAMER_TRANSPOSE_EN
    transpose_d = transpose_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_STREAM;
          row_cnt_d = '0;
`ifdef MEMB_STREAMER_TRANSPOSE_EN
          transpose_d = transpose;
`endif
        end
      end
      S_STREAM: begin
        if (row_cnt_q == RW'(DIM - 1)) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FW'(2 * DIM - 2)) state_d = S_DONE;
        else flush_cnt_d = flush_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state; the row read is combinational so same-cycle writes are seen
  always_comb begin
    busy   = (state_q == S_STREAM) || (state_q == S_FLUSH);
    en_out = busy;
    done   = (state_q == S_DONE);
    for (int j = 0; j < DIM; j++) begin
      Bout[j] = '0;
      if (state_q == S_STREAM) begin
`ifdef MEMB_STREAMER_TRANSPOSE_EN
        Bout[j] = transpose_q ? mem_q[j][row_cnt_q] : mem_q[row_cnt_q][j];
`else
        Bout[j] = mem_q[row_cnt_q][j];
`endif
      end
    end
  end

endmodule

// File: tb/tb_memb_streamer.sv
// tb/tb_memb_streamer.sv - self-checking bench for memb_streamer against a matrix-level model
module tb_memb_streamer;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      wr_en = 1'b0;
  logic [2:0]                wr_row = '0;
  logic signed [BITS_AB-1:0] wr_data [DIM-1:0];
  logic                      start = 1'b0;
  logic                      busy, done, en_out;
  logic signed [BITS_AB-1:0] Bout [DIM-1:0];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference matrix: row r, lane j lives in bits [8j+7:8j]
  logic [63:0] mdl [DIM];

  memb_streamer #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
`ifdef MEMB_STREAMER_TRANSPOSE_EN
    .transpose (1'b0),
`endif
    .busy    (busy),
    .done    (done),
    .en_out  (en_out),
    .Bout    (Bout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bout_packed();
    logic [63:0] v;
    for (int j = 0; j < DIM; j++) v[8*j +: 8] = Bout[j];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [63:0] v);
    for (int j = 0; j < DIM; j++) wr_data[j] = v[8*j +: 8];
  endtask

  task automatic write_row(input int r, input logic [63:0] v);
    wr_en = 1'b1; wr_row = 3'(r); set_data(v);
    @(posedge clk); #1;
    wr_en = 1'b0;
    mdl[r] = v;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " en"},   64'(en_out), 64'd0);
    chk({tag, " bout"}, bout_packed(), 64'd0);
  endtask

  // Pulses start (with any write the caller has already placed on the bus) and
  // checks every cycle of the expected stream / flush / done sequence.
  // poke_c: cycle in which a write of row 3 and a second start are attempted.
  // rst_c : cycle after which reset is applied; the sequence is abandoned.
  task automatic run_stream(input string tag, input int poke_c, input int rst_c);
    logic [63:0] exp_row;
    logic        exp_en, exp_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    for (int c = 1; c <= 3 * DIM + 1; c++) begin
      @(negedge clk);
      exp_en   = (c <= 3 * DIM - 1);
      exp_done = (c == 3 * DIM);
      exp_row  = (c <= DIM) ? mdl[c-1] : 64'd0;
      chk($sformatf("%s c%0d en", tag, c),   64'(en_out), 64'(exp_en));
      chk($sformatf("%s c%0d busy", tag, c), 64'(busy),   64'(exp_en));
      chk($sformatf("%s c%0d done", tag, c), 64'(done),   64'(exp_done));
      chk($sformatf("%s c%0d bout", tag, c), bout_packed(), exp_row);
      if (c == poke_c) begin
        wr_en = 1'b1; wr_row = 3'd3; set_data(64'h5555_5555_5555_5555); start = 1'b1;
      end
      if (c == rst_c) rst = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0; start = 1'b0;
      if (c == rst_c) begin
        rst = 1'b0;
        for (int r = 0; r < DIM; r++) mdl[r] = '0;
        @(negedge clk);
        check_idle({tag, " post-rst"});
        return;
      end
    end
  endtask

  initial begin
    set_data('0);
    for (int r = 0; r < DIM; r++) mdl[r] = '0;

    // Reset held two cycles
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    run_stream("zero", 0, 0);

    // B[i][j] = 8*i + j
    for (int i = 0; i < DIM; i++) begin
      logic [63:0] v;
      for (int j = 0; j < DIM; j++) v[8*j +: 8] = 8'(8 * i + j);
      write_row(i, v);
    end
    run_stream("basic", 0, 0);

    // Signed extremes on one row
    write_row(2, 64'h7F80_7F80_807F_807F);
    write_row(5, 64'h8080_8080_7F7F_7F7F);
    run_stream("extreme", 0, 0);

    // Random matrix; writes and start during STREAM must be ignored
    for (int i = 0; i < DIM; i++) write_row(i, {$urandom, $urandom});
    run_stream("rand_poke", 3, 0);
    run_stream("rand_again", 0, 0);

    // Same-cycle write of row 0 and start
    wr_en = 1'b1; wr_row = 3'd0; set_data(64'h0707_0707_0707_0707);
    mdl[0] = 64'h0707_0707_0707_0707;
    run_stream("wr_start", 0, 0);

    // Reset at stream cycle 4: no done pulse afterwards, storage cleared
    run_stream("midrst", 0, 4);
    for (int k = 0; k < 3 * DIM; k++) begin
      @(negedge clk);
      chk($sformatf("midrst idle%0d done", k), 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    run_stream("after_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/memb_streamer.md
Name: memb_streamer

Overview:
- Upstream feeder for the B-side skew buffer (memB) of the systolic array.
- Holds one DIM x DIM B matrix loaded row-by-row over a simple write port.
- On start, presents one full row per cycle on Bout with en asserted, then drives zeros so every skew FIFO drains.
- Reports completion with a one-cycle done pulse.

Parameters:
- BITS_AB, 8, element width (signed); must match memB.BITS_AB.
- DIM, 8, matrix dimension and number of lanes; must match memB.DIM; DIM >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  write one row into storage.
- wr_row  input  $clog2(DIM)  row index for the write.
- wr_data  input  signed [BITS_AB-1:0] x [DIM-1:0]  row data; lane j = B[wr_row][j].
- start  input  1  begin streaming; honoured only in IDLE.
- busy  output  1  high in STREAM and FLUSH.
- done  output  1  one-cycle pulse after the final flush cycle.
- en_out  output  1  drives memB.en.
- Bout  output  signed [BITS_AB-1:0] x [DIM-1:0]  drives memB.Bin.

Behaviour:
- Storage: DIM x DIM registers. rst clears all entries to 0.
- Reset values: FSM=IDLE, row/flush counters=0, busy=0, done=0, en_out=0, all Bout lanes=0.
- FSM states IDLE, STREAM, FLUSH, DONE. State and counters are registered.
- en_out and busy decode from state.
- Bout reads combinationally from storage[row_cnt] in STREAM; it is 0 in all other states.
- IDLE:
  - wr_en=1 writes wr_data into storage[wr_row] at the clock edge.
  - start=1 moves to STREAM with row_cnt=0.
  - If wr_en and start are high in the same cycle, both take effect. The written row is visible to the stream, because the read is combinational and happens after the edge.
- STREAM:
  - Lasts exactly DIM cycles.
  - Each cycle: en_out=1, Bout[j]=B[row_cnt][j]; row_cnt increments.
  - When row_cnt = DIM-1, move to FLUSH with flush_cnt=0.
- FLUSH:
  - Lasts exactly 2*DIM-1 cycles, the depth of the deepest memB FIFO.
  - Each cycle: en_out=1, Bout=0.
  - When flush_cnt = 2*DIM-2, move to DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0, en_out=0, Bout=0.
  - Then returns to IDLE.
- Timing summary:
  - start sampled at edge N.
  - First row is valid in cycle N+1.
  - en_out stays high for exactly 3*DIM-1 consecutive cycles.
  - done is high in cycle N+3*DIM.
- Ignored inputs:
  - wr_en when the state is not IDLE: dropped, storage unchanged. This includes writes in DONE.
  - start when the state is not IDLE: ignored, no queueing.
- wr_row >= DIM cannot occur when DIM is a power of 2. For other DIM values, an out-of-range write is dropped.
- rst mid-operation: the next edge forces the reset values and clears storage. No done pulse is produced.
- After DONE, storage is retained. A second start re-streams the same matrix unless it is rewritten.

Optional Feature:
- Macro: MEMB_STREAMER_TRANSPOSE_EN.
- Defined:
  - Adds input port transpose (1 bit), sampled together with start.
  - If transpose was 1 at start, STREAM emits Bout[j]=B[j][row_cnt], i.e. column row_cnt of the stored matrix.
  - Timing, counts and flush are unchanged.
- Undefined:
  - No transpose port.
  - Rows only, as described in Behaviour.

Test Plan:
- Reset check: assert rst for 2 cycles -> busy=0, done=0, en_out=0, all Bout=0. Start immediately after -> streamed rows all 0.
- Basic stream, DIM=8, B[i][j]=8*i+j:
  - Write all 8 rows, pulse start.
  - Cycles 1..8: en_out=1, Bout = {8k..8k+7} for k=0..7.
  - Cycles 9..23: en_out=1, Bout=0.
  - Cycle 24: done=1.
  - Cycle 25: IDLE.
- Signed extremes: a row of -128 and 127 values appears unmodified on Bout. After feeding memB, lane i output of memB first equals B[0][i] after DIM+i en cycles.
- Busy ignores:
  - During STREAM, write row 3 with all 0x55 and pulse start again.
  - Required: storage is unchanged and the stream length is still 3*DIM-1.
  - Required: a later restart shows the original row 3.
- Same-cycle write+start: in IDLE, write row 0 = all 7 while start=1 -> first streamed row is all 7.
- Reset mid-stream: assert rst at stream cycle 4 -> next cycle en_out=0 with no done pulse. Restart -> rows all 0.
